// File: rtl/hazard_control_unit.sv
// Hazard control for the 5-stage MIPS pipeline: multi-cycle load-use stalls, mult/div
// HI/LO interlock and branch flush. Optional stall counter enabled by HAZARD_PERF_CNT_EN.
module hazard_control_unit #(
    parameter int REG_ADDR_W        = 5,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MD_LATENCY        = 32,
    parameter int MD_CNT_W          = 6,
    parameter int PERF_CNT_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  mem_read,
    input  logic                  id_uses_hilo,
    input  logic                  id_is_md,
    input  logic                  md_start,
    input  logic                  branch_taken,
`ifdef HAZARD_PERF_CNT_EN
    input  logic                  stall_count_clr,
    output logic [PERF_CNT_W-1:0] stall_count,
`endif
    output logic                  hazard_flag,
    output logic                  if_id_write_enable,
    output logic                  pc_write_enable,
    output logic                  if_id_flush,
    output logic                  md_busy
);

    localparam int LOAD_CNT_W = 3;

    if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7 || MD_LATENCY < 1 ||
        MD_LATENCY >= (1 << MD_CNT_W) || PERF_CNT_W < 1) begin : g_bad_params
        $error("hazard_control_unit: illegal parameter combination");
    end

    typedef enum logic {
        IDLE,
        LOAD_STALL
    } state_t;

    state_t                state_q, state_d;
    logic [LOAD_CNT_W-1:0] load_cnt_q, load_cnt_d;
    logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;
    logic                  load_hit;
    logic                  md_busy_int;
    logic                  md_hit;
    logic                  stall;

    // Register 0 is hard-wired to zero, so a load targeting it never creates a dependency.
    assign load_hit    = mem_read && (ex_rt != '0) && ((id_rs == ex_rt) || (id_rt == ex_rt));
    assign md_busy_int = (md_cnt_q != '0) || md_start;
    assign md_hit      = md_busy_int && (id_uses_hilo || id_is_md);

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        stall      = 1'b0;
        case (state_q)
            IDLE: begin
                stall = load_hit || md_hit;
                if (load_hit && (LOAD_STALL_CYCLES > 1)) begin
                    state_d    = LOAD_STALL;
                    load_cnt_d = LOAD_CNT_W'(LOAD_STALL_CYCLES - 1);
                end
            end
            LOAD_STALL: begin
                // ID/EX already holds a bubble here, so ex_rt no longer describes the load.
                stall      = 1'b1;
                load_cnt_d = load_cnt_q - LOAD_CNT_W'(1);
                if (load_cnt_q == LOAD_CNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = MD_CNT_W'(MD_LATENCY);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            md_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            md_cnt_q   <= md_cnt_d;
        end
    end

    // Stall outranks flush: a taken branch waits in ID until the stall clears.
    always_comb begin
        if (rst) begin
            hazard_flag        = 1'b0;
            if_id_write_enable = 1'b1;
            pc_write_enable    = 1'b1;
            if_id_flush        = 1'b0;
            md_busy            = 1'b0;
        end else begin
            hazard_flag        = stall;
            if_id_write_enable = !stall;
            pc_write_enable    = !stall;
            if_id_flush        = branch_taken && !stall;
            md_busy            = md_busy_int;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_W-1:0] stall_count_q;

    always_ff @(posedge clk) begin
        if (rst || stall_count_clr) begin
            stall_count_q <= '0;
        end else if (stall && !(&stall_count_q)) begin
            stall_count_q <= stall_count_q + PERF_CNT_W'(1);
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (1- and 3-cycle load stalls) driven in parallel,
// directed vector table, then random stimulus against a timeline-based reference model.
module tb_hazard_control_unit;

    localparam int MDL = 4;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       mem_read, id_uses_hilo, id_is_md, md_start, branch_taken;
    logic       stall_count_clr;

    logic hf_a, ifw_a, pcw_a, fl_a, mb_a;
    logic hf_b, ifw_b, pcw_b, fl_b, mb_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_errors = 0;

    hazard_control_unit #(.LOAD_STALL_CYCLES(1), .MD_LATENCY(MDL), .PERF_CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
        .mem_read(mem_read), .id_uses_hilo(id_uses_hilo), .id_is_md(id_is_md),
        .md_start(md_start), .branch_taken(branch_taken),
`ifdef HAZARD_PERF_CNT_EN
        .stall_count_clr(stall_count_clr), .stall_count(cnt_a),
`endif
        .hazard_flag(hf_a), .if_id_write_enable(ifw_a), .pc_write_enable(pcw_a),
        .if_id_flush(fl_a), .md_busy(mb_a)
    );

    hazard_control_unit #(.LOAD_STALL_CYCLES(3), .MD_LATENCY(MDL), .PERF_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
        .mem_read(mem_read), .id_uses_hilo(id_uses_hilo), .id_is_md(id_is_md),
        .md_start(md_start), .branch_taken(branch_taken),
`ifdef HAZARD_PERF_CNT_EN
        .stall_count_clr(stall_count_clr), .stall_count(cnt_b),
`endif
        .hazard_flag(hf_b), .if_id_write_enable(ifw_b), .pc_write_enable(pcw_b),
        .if_id_flush(fl_b), .md_busy(mb_b)
    );

`ifndef HAZARD_PERF_CNT_EN
    assign cnt_a = '0;
    assign cnt_b = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog expired");
    end

    // {hazard_flag, if_id_write_enable, pc_write_enable, if_id_flush, md_busy}
    logic [4:0] out_a, out_b;
    assign out_a = {hf_a, ifw_a, pcw_a, fl_a, mb_a};
    assign out_b = {hf_b, ifw_b, pcw_b, fl_b, mb_b};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: absolute cycle numbers instead of counters.
    // A load hit at cycle t stalls cycles t..t+LSC-1; md_start at cycle s keeps HI/LO
    // pending for cycles s+1..s+MDL.
    int lsc[2]      = '{1, 3};
    int pmax[2]     = '{65535, 3};
    int cyc         = 0;
    int ld_until[2] = '{0, 0};
    int md_ready[2] = '{0, 0};
    int pcnt[2]     = '{0, 0};
    logic [4:0] m_exp[2];
    logic       m_stall[2];
    logic       m_ldhit;

    task automatic model_eval();
        logic busy;
        m_ldhit = mem_read && (ex_rt != 0) && ((id_rs == ex_rt) || (id_rt == ex_rt));
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_exp[k]   = 5'b01100;
                m_stall[k] = 1'b0;
            end else begin
                busy       = md_start || (cyc < md_ready[k]);
                m_stall[k] = (cyc < ld_until[k]) || m_ldhit || (busy && (id_uses_hilo || id_is_md));
                m_exp[k]   = {m_stall[k], !m_stall[k], !m_stall[k],
                              branch_taken && !m_stall[k], busy};
            end
        end
    endtask

    task automatic model_commit();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                ld_until[k] = 0;
                md_ready[k] = 0;
                pcnt[k]     = 0;
            end else begin
                if (cyc >= ld_until[k] && m_ldhit) ld_until[k] = cyc + lsc[k];
                if (md_start) md_ready[k] = cyc + 1 + MDL;
                if (stall_count_clr) pcnt[k] = 0;
                else if (m_stall[k] && pcnt[k] < pmax[k]) pcnt[k]++;
            end
        end
        cyc++;
    endtask

    // One clock cycle: inputs were set just after the previous rising edge.
    task automatic step(input string tag, input logic use_tab, input logic [4:0] ea,
                        input logic [4:0] eb);
        @(negedge clk);
        model_eval();
        if (use_tab) begin
            check({tag, "_a"}, 32'(out_a), 32'(ea));
            check({tag, "_b"}, 32'(out_b), 32'(eb));
        end else begin
            check({tag, "_a"}, 32'(out_a), 32'(m_exp[0]));
            check({tag, "_b"}, 32'(out_b), 32'(m_exp[1]));
        end
`ifdef HAZARD_PERF_CNT_EN
        check({tag, "_cnt_a"}, 32'(cnt_a), 32'(pcnt[0]));
        check({tag, "_cnt_b"}, 32'(cnt_b), 32'(pcnt[1]));
`endif
        model_commit();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       r;
        logic [4:0] rs, rt, ex;
        logic       mr, hilo, ismd, mds, br;
        logic [4:0] ea, eb;
    } vec_t;

    function automatic vec_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic [4:0] ex,
                                logic mr, logic hilo, logic ismd, logic mds, logic br,
                                logic [4:0] ea, logic [4:0] eb);
        vec_t v;
        v.r = r; v.rs = rs; v.rt = rt; v.ex = ex; v.mr = mr; v.hilo = hilo;
        v.ismd = ismd; v.mds = mds; v.br = br; v.ea = ea; v.eb = eb;
        return v;
    endfunction

    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] ex, input logic mr, input logic hilo,
                         input logic ismd, input logic mds, input logic br, input logic clr);
        rst = r; id_rs = rs; id_rt = rt; ex_rt = ex; mem_read = mr;
        id_uses_hilo = hilo; id_is_md = ismd; md_start = mds; branch_taken = br;
        stall_count_clr = clr;
    endtask

    vec_t tab[24];

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //            rst rs rt ex mr hl md ms br  exp_a     exp_b
        tab[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 5'b01100, 5'b01100);
        tab[1]  = mk(0, 8, 0, 8, 1, 0, 0, 0, 0, 5'b10000, 5'b10000);
        tab[2]  = mk(0, 8, 0, 8, 0, 0, 0, 0, 0, 5'b01100, 5'b10000);
        tab[3]  = mk(0, 8, 0, 8, 0, 0, 0, 0, 0, 5'b01100, 5'b10000);
        tab[4]  = mk(0, 8, 0, 8, 0, 0, 0, 0, 0, 5'b01100, 5'b01100);
        tab[5]  = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 5'b01100, 5'b01100);
        tab[6]  = mk(0, 3, 8, 8, 1, 0, 0, 0, 0, 5'b10000, 5'b10000);
        tab[7]  = mk(0, 3, 8, 8, 0, 0, 0, 0, 1, 5'b01110, 5'b10000);
        tab[8]  = mk(0, 3, 8, 8, 0, 0, 0, 0, 1, 5'b01110, 5'b10000);
        tab[9]  = mk(0, 3, 8, 8, 0, 0, 0, 0, 1, 5'b01110, 5'b01110);
        tab[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01100, 5'b01100);
        tab[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b01101, 5'b01101);
        tab[12] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b10001, 5'b10001);
        tab[13] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b10001, 5'b10001);
        tab[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b10001, 5'b10001);
        tab[15] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b10001, 5'b10001);
        tab[16] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b01100, 5'b01100);
        tab[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01100, 5'b01100);
        tab[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b01101, 5'b01101);
        tab[19] = mk(0, 8, 0, 8, 1, 0, 0, 0, 0, 5'b10001, 5'b10001);
        tab[20] = mk(1, 8, 0, 8, 0, 1, 0, 0, 0, 5'b01100, 5'b01100);
        tab[21] = mk(0, 8, 0, 8, 0, 1, 0, 0, 0, 5'b01100, 5'b01100);
        tab[22] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b01100, 5'b01100);
        tab[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'b01110, 5'b01110);

        for (int i = 0; i < 24; i++) begin
            drive(tab[i].r, tab[i].rs, tab[i].rt, tab[i].ex, tab[i].mr, tab[i].hilo,
                  tab[i].ismd, tab[i].mds, tab[i].br, 1'b0);
            step($sformatf("vec%0d", i), 1'b1, tab[i].ea, tab[i].eb);
        end

        // Random traffic on a small register set so hits, md overlap and resets collide often.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rnd_rst", 1'b0, 5'b0, 5'b0);
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 59) == 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
            step($sformatf("rnd%0d", i), 1'b0, 5'b0, 5'b0);
        end

        // Continuous load-use for five cycles, then a clear during the stall.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("perf_rst", 1'b0, 5'b0, 5'b0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 8, 0, 8, 1, 0, 0, 0, 0, 0);
            step($sformatf("perf_stall%0d", i), 1'b1, 5'b10000, 5'b10000);
        end
`ifdef HAZARD_PERF_CNT_EN
        check("perf_sat_b", 32'(cnt_b), 32'd3);
        check("perf_cnt_a", 32'(cnt_a), 32'd5);
        drive(0, 8, 0, 8, 1, 0, 0, 0, 0, 1);
        step("perf_clr", 1'b0, 5'b0, 5'b0);
        check("perf_clr_b", 32'(cnt_b), 32'd0);
        check("perf_clr_a", 32'(cnt_a), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
